rename_map_table: RTL and testbench

Speculative Rename Map Table (RMT) for the 4-wide rename stage. It maps each logical register to its current speculative physical register. Each cycle it serves up to four renaming instructions with source lookups, old-destination lookups and new-destination writes, including intra-group bypass. On a recovery it receives the 4-entries-per-cycle restore stream sent by the architectural map table and rebuilds the speculative state from it, stalling rename until the restore completes.

---
 rtl/rename_map_table_if.sv | 52 +++++
 rtl/rename_map_table.sv | 107 ++++++++++
 tb/tb_rename_map_table.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/rename_map_table_if.sv
// rename_map_table_if: rename/recovery bundle for the speculative rename map table.
// master drives rename slots 0..3 (slot 0 oldest) and the restore stream, and
// receives renamed sources, old destination mappings and recovery status;
// slave is the map table side.
interface rename_map_table_if #(
  parameter int NUM_LOG = 32,
  parameter int LOG_W = 5,
  parameter int PHY_W = 7
);
  logic renValid0_i, renValid1_i, renValid2_i, renValid3_i;
  logic [LOG_W-1:0] src1Log0_i, src1Log1_i, src1Log2_i, src1Log3_i;
  logic [LOG_W-1:0] src2Log0_i, src2Log1_i, src2Log2_i, src2Log3_i;
  logic destValid0_i, destValid1_i, destValid2_i, destValid3_i;
  logic [LOG_W-1:0] destLog0_i, destLog1_i, destLog2_i, destLog3_i;
  logic [PHY_W-1:0] newPhy0_i, newPhy1_i, newPhy2_i, newPhy3_i;
  logic [PHY_W-1:0] src1Phy0_o, src1Phy1_o, src1Phy2_o, src1Phy3_o;
  logic [PHY_W-1:0] src2Phy0_o, src2Phy1_o, src2Phy2_o, src2Phy3_o;
  logic [PHY_W-1:0] oldPhy0_o, oldPhy1_o, oldPhy2_o, oldPhy3_o;
  logic recoverFlag_i;
  logic [LOG_W+PHY_W-1:0] recoverPacket0_i, recoverPacket1_i, recoverPacket2_i, recoverPacket3_i;
  logic stall_o;
  logic recoveryDone_o;
  logic recoverError_o;
  modport master (
    output renValid0_i, renValid1_i, renValid2_i, renValid3_i,
    output src1Log0_i, src1Log1_i, src1Log2_i, src1Log3_i,
    output src2Log0_i, src2Log1_i, src2Log2_i, src2Log3_i,
    output destValid0_i, destValid1_i, destValid2_i, destValid3_i,
    output destLog0_i, destLog1_i, destLog2_i, destLog3_i,
    output newPhy0_i, newPhy1_i, newPhy2_i, newPhy3_i,
    input src1Phy0_o, src1Phy1_o, src1Phy2_o, src1Phy3_o,
    input src2Phy0_o, src2Phy1_o, src2Phy2_o, src2Phy3_o,
    input oldPhy0_o, oldPhy1_o, oldPhy2_o, oldPhy3_o,
    output recoverFlag_i,
    output recoverPacket0_i, recoverPacket1_i, recoverPacket2_i, recoverPacket3_i,
    input stall_o, recoveryDone_o, recoverError_o
  );
  modport slave (
    input renValid0_i, renValid1_i, renValid2_i, renValid3_i,
    input src1Log0_i, src1Log1_i, src1Log2_i, src1Log3_i,
    input src2Log0_i, src2Log1_i, src2Log2_i, src2Log3_i,
    input destValid0_i, destValid1_i, destValid2_i, destValid3_i,
    input destLog0_i, destLog1_i, destLog2_i, destLog3_i,
    input newPhy0_i, newPhy1_i, newPhy2_i, newPhy3_i,
    output src1Phy0_o, src1Phy1_o, src1Phy2_o, src1Phy3_o,
    output src2Phy0_o, src2Phy1_o, src2Phy2_o, src2Phy3_o,
    output oldPhy0_o, oldPhy1_o, oldPhy2_o, oldPhy3_o,
    input recoverFlag_i,
    input recoverPacket0_i, recoverPacket1_i, recoverPacket2_i, recoverPacket3_i,
    output stall_o, recoveryDone_o, recoverError_o
  );
endinterface

// File: rtl/rename_map_table.sv
// rename_map_table: 4-wide speculative rename map table with restore-stream recovery.
// Ports: clk, reset (sync, active-high), bus (rename_map_table_if.slave): rename
// lookups/writes for slots 0..3, restore packets {log, phy}, stall/done/error status.
// Optional macro RMT_RECOVER_CHECK_EN: checks restore packet ordering and stream
// length, flagging a sticky recoverError_o; otherwise recoverError_o is 0.
module rename_map_table #(
  parameter int NUM_LOG = 32,
  parameter int LOG_W = 5,
  parameter int PHY_W = 7
) (
  input logic clk,
  input logic reset,
  rename_map_table_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RESTORE, DONE} state_e;
  state_e state, stateNext;
  logic [PHY_W-1:0] mapTable [NUM_LOG];
  logic [3:0] renValid, destValid;
  logic [LOG_W-1:0] src1Log [4];
  logic [LOG_W-1:0] src2Log [4];
  logic [LOG_W-1:0] destLog [4];
  logic [PHY_W-1:0] newPhy [4];
  logic [PHY_W-1:0] src1Phy [4];
  logic [PHY_W-1:0] src2Phy [4];
  logic [PHY_W-1:0] oldPhy [4];
  logic [LOG_W+PHY_W-1:0] packet [4];
  logic stall;
  assign renValid = {bus.renValid3_i, bus.renValid2_i, bus.renValid1_i, bus.renValid0_i};
  assign destValid = {bus.destValid3_i, bus.destValid2_i, bus.destValid1_i, bus.destValid0_i};
  assign src1Log = '{bus.src1Log0_i, bus.src1Log1_i, bus.src1Log2_i, bus.src1Log3_i};
  assign src2Log = '{bus.src2Log0_i, bus.src2Log1_i, bus.src2Log2_i, bus.src2Log3_i};
  assign destLog = '{bus.destLog0_i, bus.destLog1_i, bus.destLog2_i, bus.destLog3_i};
  assign newPhy = '{bus.newPhy0_i, bus.newPhy1_i, bus.newPhy2_i, bus.newPhy3_i};
  assign packet = '{bus.recoverPacket0_i, bus.recoverPacket1_i, bus.recoverPacket2_i, bus.recoverPacket3_i};
  assign bus.src1Phy0_o = src1Phy[0];
  assign bus.src1Phy1_o = src1Phy[1];
  assign bus.src1Phy2_o = src1Phy[2];
  assign bus.src1Phy3_o = src1Phy[3];
  assign bus.src2Phy0_o = src2Phy[0];
  assign bus.src2Phy1_o = src2Phy[1];
  assign bus.src2Phy2_o = src2Phy[2];
  assign bus.src2Phy3_o = src2Phy[3];
  assign bus.oldPhy0_o = oldPhy[0];
  assign bus.oldPhy1_o = oldPhy[1];
  assign bus.oldPhy2_o = oldPhy[2];
  assign bus.oldPhy3_o = oldPhy[3];
  assign stall = bus.recoverFlag_i | (state != IDLE);
  assign bus.stall_o = stall;
  assign bus.recoveryDone_o = (state == DONE);
  // Ascending scan so the youngest older writer of q wins the bypass.
  function automatic logic [PHY_W-1:0] lookup(input int k, input logic [LOG_W-1:0] q);
    lookup = mapTable[q];
    for (int j = 0; j < 3; j++)
      if (j < k && renValid[j] && destValid[j] && destLog[j] == q) lookup = newPhy[j];
  endfunction
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      src1Phy[k] = lookup(k, src1Log[k]);
      src2Phy[k] = lookup(k, src2Log[k]);
      oldPhy[k] = lookup(k, destLog[k]);
    end
  end
  // Later writes in each loop override earlier ones, so the youngest slot wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_LOG; i++) mapTable[i] <= PHY_W'(i);
    end else if (bus.recoverFlag_i) begin
      for (int k = 0; k < 4; k++) mapTable[packet[k][LOG_W+PHY_W-1:PHY_W]] <= packet[k][PHY_W-1:0];
    end else if (!stall) begin
      for (int k = 0; k < 4; k++)
        if (renValid[k] && destValid[k]) mapTable[destLog[k]] <= newPhy[k];
    end
  end
  always_ff @(posedge clk) state <= reset ? IDLE : stateNext;
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: stateNext = bus.recoverFlag_i ? RESTORE : IDLE;
      RESTORE: stateNext = bus.recoverFlag_i ? RESTORE : DONE;
      default: stateNext = IDLE;
    endcase
  end
`ifdef RMT_RECOVER_CHECK_EN
  localparam int BEATS = NUM_LOG / 4;
  localparam int BCW = BEATS > 1 ? $clog2(BEATS) : 1;
  logic [BCW-1:0] beatCnt;
  logic recoverError, beatError;
  always_ff @(posedge clk) begin
    if (reset) beatCnt <= '0;
    else if (state == DONE) beatCnt <= '0;
    else if (bus.recoverFlag_i) beatCnt <= (beatCnt == BCW'(BEATS - 1)) ? '0 : beatCnt + 1'b1;
  end
  // Beat b must carry logical indices 4b..4b+3 in slot order; a stream ending
  // with beatCnt != 0 was short or overran the table.
  always_comb begin
    beatError = 1'b0;
    for (int k = 0; k < 4; k++)
      if (bus.recoverFlag_i && packet[k][LOG_W+PHY_W-1:PHY_W] != LOG_W'({beatCnt, 2'b00}) + LOG_W'(k))
        beatError = 1'b1;
    if (state == RESTORE && !bus.recoverFlag_i && beatCnt != '0) beatError = 1'b1;
  end
  always_ff @(posedge clk) recoverError <= reset ? 1'b0 : (recoverError | beatError);
  assign bus.recoverError_o = recoverError;
`else
  assign bus.recoverError_o = 1'b0;
`endif
endmodule

// File: tb/tb_rename_map_table.sv
// tb_rename_map_table: directed self-checking bench for rename_map_table.
module tb_rename_map_table;
  localparam int NL = 32;
  localparam int LW = 5;
  localparam int PW = 7;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  rename_map_table_if #(.NUM_LOG(NL), .LOG_W(LW), .PHY_W(PW)) bus ();
  rename_map_table #(.NUM_LOG(NL), .LOG_W(LW), .PHY_W(PW)) dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clearIn();
    {bus.renValid0_i, bus.renValid1_i, bus.renValid2_i, bus.renValid3_i} = '0;
    {bus.destValid0_i, bus.destValid1_i, bus.destValid2_i, bus.destValid3_i} = '0;
    {bus.src1Log0_i, bus.src1Log1_i, bus.src1Log2_i, bus.src1Log3_i} = '0;
    {bus.src2Log0_i, bus.src2Log1_i, bus.src2Log2_i, bus.src2Log3_i} = '0;
    {bus.destLog0_i, bus.destLog1_i, bus.destLog2_i, bus.destLog3_i} = '0;
    {bus.newPhy0_i, bus.newPhy1_i, bus.newPhy2_i, bus.newPhy3_i} = '0;
    bus.recoverFlag_i = 1'b0;
    {bus.recoverPacket0_i, bus.recoverPacket1_i, bus.recoverPacket2_i, bus.recoverPacket3_i} = '0;
  endtask
  task automatic pulseReset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask
  task automatic setBeat(input int b, input int phyBase, input bit bad);
    bus.recoverFlag_i = 1'b1;
    bus.recoverPacket0_i = {LW'(4 * b + (bad ? 1 : 0)), PW'(phyBase + 4 * b)};
    bus.recoverPacket1_i = {LW'(4 * b + 1), PW'(phyBase + 4 * b + 1)};
    bus.recoverPacket2_i = {LW'(4 * b + 2), PW'(phyBase + 4 * b + 2)};
    bus.recoverPacket3_i = {LW'(4 * b + 3), PW'(phyBase + 4 * b + 3)};
  endtask
  task automatic runStream(input int first, input int last, input int phyBase, input int badBeat);
    for (int b = first; b < last; b++) begin
      setBeat(b, phyBase, b == badBeat);
      #2 check("stallBeat", bus.stall_o, 1);
      step();
    end
    bus.recoverFlag_i = 1'b0;
  endtask
  task automatic waitDone(output int pulses, output int errAtDone);
    pulses = 0;
    errAtDone = 0;
    for (int i = 0; i < 6; i++) begin
      #2;
      if (bus.recoveryDone_o) begin
        pulses++;
        errAtDone = int'(bus.recoverError_o);
        check("stallDone", bus.stall_o, 1);
      end
      step();
    end
    check("donePulses", pulses, 1);
  endtask
  initial begin
    int pulses, errAtDone;
    clearIn();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    bus.src1Log0_i = 5'd7;
    bus.destLog3_i = 5'd31;
    bus.src2Log2_i = 5'd18;
    #2;
    check("rstStall", bus.stall_o, 0);
    check("rstDone", bus.recoveryDone_o, 0);
    check("rstErr", bus.recoverError_o, 0);
    check("rstSrc1Phy0", bus.src1Phy0_o, 7);
    check("rstOldPhy3", bus.oldPhy3_o, 31);
    check("rstSrc2Phy2", bus.src2Phy2_o, 18);
    step();
    clearIn();
    {bus.renValid0_i, bus.renValid1_i, bus.renValid2_i, bus.renValid3_i} = 4'b1111;
    bus.destValid0_i = 1'b1;
    bus.destLog0_i = 5'd5;
    bus.newPhy0_i = 7'd40;
    bus.destValid2_i = 1'b1;
    bus.destLog2_i = 5'd5;
    bus.newPhy2_i = 7'd41;
    bus.src1Log1_i = 5'd5;
    bus.src1Log3_i = 5'd5;
    bus.src2Log3_i = 5'd5;
    bus.src2Log0_i = 5'd5;
    #2;
    check("bypSrc1Phy1", bus.src1Phy1_o, 40);
    check("bypSrc1Phy3", bus.src1Phy3_o, 41);
    check("bypSrc2Phy3", bus.src2Phy3_o, 41);
    check("bypSrc2Phy0", bus.src2Phy0_o, 5);
    check("bypOldPhy2", bus.oldPhy2_o, 40);
    check("bypOldPhy0", bus.oldPhy0_o, 5);
    step();
    clearIn();
    bus.src1Log0_i = 5'd5;
    #2 check("wrYoungest", bus.src1Phy0_o, 41);
    step();
    for (int b = 0; b < 8; b++) begin
      setBeat(b, 60, 1'b0);
      if (b == 3) begin
        bus.renValid0_i = 1'b1;
        bus.destValid0_i = 1'b1;
        bus.destLog0_i = 5'd1;
        bus.newPhy0_i = 7'd100;
      end
      #2 check("stallBeat", bus.stall_o, 1);
      step();
      clearIn();
    end
    waitDone(pulses, errAtDone);
    bus.src1Log0_i = 5'd9;
    bus.src1Log1_i = 5'd1;
    bus.src2Log2_i = 5'd14;
    bus.src2Log3_i = 5'd5;
    #2;
    check("restStall", bus.stall_o, 0);
    check("restR9", bus.src1Phy1_o == bus.src1Phy1_o ? bus.src1Phy0_o : 0, 69);
    check("restR1NoRename", bus.src1Phy1_o, 61);
    check("restR14", bus.src2Phy2_o, 74);
    check("restR5", bus.src2Phy3_o, 65);
    check("restErr", bus.recoverError_o, 0);
    step();
    clearIn();
    runStream(0, 3, 90, -1);
    setBeat(3, 90, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    clearIn();
    bus.src1Log0_i = 5'd0;
    bus.src1Log1_i = 5'd5;
    bus.src1Log2_i = 5'd9;
    bus.src1Log3_i = 5'd13;
    #2;
    check("midRstStall", bus.stall_o, 0);
    check("midRstDone", bus.recoveryDone_o, 0);
    check("midRstErr", bus.recoverError_o, 0);
    check("midRstR0", bus.src1Phy0_o, 0);
    check("midRstR5", bus.src1Phy1_o, 5);
    check("midRstR9", bus.src1Phy2_o, 9);
    check("midRstR13", bus.src1Phy3_o, 13);
    step();
    runStream(0, 8, 20, -1);
    waitDone(pulses, errAtDone);
    check("cleanErr", bus.recoverError_o, 0);
    runStream(0, 5, 60, -1);
    waitDone(pulses, errAtDone);
`ifdef RMT_RECOVER_CHECK_EN
    check("shortErrDone", errAtDone, 1);
    step();
    check("shortErrHeld", bus.recoverError_o, 1);
    pulseReset();
    check("shortErrCleared", bus.recoverError_o, 0);
    runStream(0, 3, 60, 2);
    #2 check("badIdxErr", bus.recoverError_o, 1);
    runStream(3, 8, 60, -1);
    waitDone(pulses, errAtDone);
    check("badIdxHeld", bus.recoverError_o, 1);
    pulseReset();
    check("badIdxCleared", bus.recoverError_o, 0);
`else
    check("shortNoCheck", errAtDone, 0);
    check("shortNoCheckAfter", bus.recoverError_o, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
